// File: rtl/board_move_writer_if.sv
// Move-request and board-state bundle between the game controller and board_move_writer.
// master drives requests and observes the board; slave is the board writer itself.
interface board_move_writer_if #(
  parameter int CELLS  = 9,
  parameter int IDX_W  = 4,
  parameter int CODE_W = 2
);
  logic                    clear;
  logic                    move_valid;
  logic [IDX_W-1:0]        move_idx;
  logic                    move_ready;
  logic                    move_done;
  logic                    move_err;
  logic                    turn;
  logic [CELLS*CODE_W-1:0] board;
  logic                    game_over;
  logic [CODE_W-1:0]       winner;

  modport master (
    output clear, move_valid, move_idx,
    input  move_ready, move_done, move_err, turn, board, game_over, winner
  );

  modport slave (
    input  clear, move_valid, move_idx,
    output move_ready, move_done, move_err, turn, board, game_over, winner
  );
endinterface

// File: rtl/board_move_writer.sv
// Board write side: validates one move per handshake and writes the player's code into the cell.
// Define BOARD_WIN_DETECT_EN to latch win/draw results and reject moves once the game is over.
module board_move_writer #(
  parameter int CELLS  = 9,
  parameter int IDX_W  = 4,
  parameter int CODE_W = 2
) (
  input logic                clk,
  input logic                reset,
  board_move_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, RESP} state_e;

  localparam logic [CODE_W-1:0] CODE_X = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_O = CODE_W'(2);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    chk_q, chk_d;
  logic                    err_q, err_d;
  logic [CELLS*CODE_W-1:0] board_q, board_d;
  logic                    turn_q, turn_d;
  logic                    done_q, done_d;
  logic                    rej_q, rej_d;
  logic                    over_q, over_d;
  logic [CODE_W-1:0]       win_q, win_d;

  logic                    occupied;
  logic                    illegal;
  logic [CELLS*CODE_W-1:0] board_wr;

`ifdef BOARD_WIN_DETECT_EN
  localparam int unsigned LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic [CODE_W-1:0] line_winner(input logic [CELLS*CODE_W-1:0] b);
    logic [CODE_W-1:0] w;
    logic [CODE_W-1:0] c0, c1, c2;
    w = '0;
    for (int l = 0; l < 8; l++) begin
      c0 = b[CODE_W*LINES[l][0] +: CODE_W];
      c1 = b[CODE_W*LINES[l][1] +: CODE_W];
      c2 = b[CODE_W*LINES[l][2] +: CODE_W];
      if (c0 != '0 && c0 == c1 && c1 == c2) w = c0;
    end
    return w;
  endfunction

  function automatic logic board_full(input logic [CELLS*CODE_W-1:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < CELLS; i++)
      if (b[CODE_W*i +: CODE_W] == '0) full = 1'b0;
    return full;
  endfunction
`endif

  // Legality of the captured index, and the board as it would look after writing it.
  always_comb begin
    occupied = 1'b0;
    board_wr = board_q;
    for (int i = 0; i < CELLS; i++) begin
      if (int'(idx_q) == i) begin
        if (board_q[CODE_W*i +: CODE_W] != '0) occupied = 1'b1;
        board_wr[CODE_W*i +: CODE_W] = turn_q ? CODE_O : CODE_X;
      end
    end
`ifdef BOARD_WIN_DETECT_EN
    illegal = (int'(idx_q) >= CELLS) || occupied || over_q;
`else
    illegal = (int'(idx_q) >= CELLS) || occupied;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    err_d   = err_q;
    board_d = board_q;
    turn_d  = turn_q;
    over_d  = over_q;
    win_d   = win_q;
    done_d  = 1'b0;
    rej_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.move_valid) begin
          idx_d   = bus.move_idx;
          chk_d   = 1'b0;
          state_d = CHECK;
        end
      end
      // First CHECK cycle registers the verdict; the second acts on it.
      CHECK: begin
        if (!chk_q) begin
          err_d = illegal;
          chk_d = 1'b1;
        end else if (err_q) begin
          rej_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        board_d = board_wr;
        turn_d  = ~turn_q;
        done_d  = 1'b1;
        state_d = RESP;
`ifdef BOARD_WIN_DETECT_EN
        if (line_winner(board_wr) != '0) begin
          over_d = 1'b1;
          win_d  = line_winner(board_wr);
        end else if (board_full(board_wr)) begin
          over_d = 1'b1;
          win_d  = '0;
        end
`else
        over_d = 1'b0;
        win_d  = '0;
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // New-game request overrides whatever the FSM was doing, including an incoming handshake.
    if (bus.clear) begin
      state_d = IDLE;
      chk_d   = 1'b0;
      err_d   = 1'b0;
      board_d = '0;
      turn_d  = 1'b0;
      over_d  = 1'b0;
      win_d   = '0;
      done_d  = 1'b0;
      rej_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
      board_q <= '0;
      turn_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      board_q <= board_d;
      turn_q  <= turn_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign bus.move_ready = (state_q == IDLE);
  assign bus.move_done  = done_q;
  assign bus.move_err   = rej_q;
  assign bus.turn       = turn_q;
  assign bus.board      = board_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = win_q;

endmodule

// File: tb/tb_board_move_writer.sv
// Directed bench for board_move_writer: legal/illegal moves, latency, clear/reset aborts, win latch.
module tb_board_move_writer;

  localparam int CELLS  = 9;
  localparam int IDX_W  = 4;
  localparam int CODE_W = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  board_move_writer_if #(.CELLS(CELLS), .IDX_W(IDX_W), .CODE_W(CODE_W)) bus ();

  board_move_writer #(.CELLS(CELLS), .IDX_W(IDX_W), .CODE_W(CODE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // Issues one request from a negedge in IDLE and watches six edges after the accept edge.
  // Positions are edge offsets from the accept edge; -1 means never seen.
  task automatic run_move(input logic [IDX_W-1:0] idx, output int done_at, output int err_at,
                          output int done_cnt, output int err_cnt, output int ready_at,
                          output logic over_at_done);
    done_at = -1; err_at = -1; done_cnt = 0; err_cnt = 0; ready_at = -1; over_at_done = 1'b0;
    bus.move_valid = 1'b1;
    bus.move_idx   = idx;
    @(posedge clk);
    #1;
    bus.move_valid = 1'b0;
    bus.move_idx   = ~idx;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.move_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = k;
          over_at_done = bus.game_over;
        end
      end
      if (bus.move_err) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
      if (bus.move_ready && ready_at < 0) ready_at = k;
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.clear = 1'b0; bus.move_valid = 1'b0; bus.move_idx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.move_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.move_ready); end
    checks++; if (bus.move_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.move_done); end
    checks++; if (bus.move_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.move_err); end
    checks++; if (bus.board !== 18'h0) begin errors++; $display("FAIL reset_board got %h exp 0", bus.board); end
    checks++; if (bus.turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %b exp 0", bus.turn); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_over got %b exp 0", bus.game_over); end
    checks++; if (bus.winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b exp 00", bus.winner); end
  endtask

  task automatic test_legal_move();
    int da, ea, dc, ec, ra; logic ov;
    run_move(4'd4, da, ea, dc, ec, ra, ov);
    checks++; if (da !== 3) begin errors++; $display("FAIL legal_done_at got %0d exp 3", da); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL legal_done_cnt got %0d exp 1", dc); end
    checks++; if (ec !== 0) begin errors++; $display("FAIL legal_err_cnt got %0d exp 0", ec); end
    checks++; if (ra !== 4) begin errors++; $display("FAIL legal_ready_at got %0d exp 4", ra); end
    checks++; if (bus.board !== 18'h00100) begin errors++; $display("FAIL legal_board got %h exp 00100", bus.board); end
    checks++; if (bus.turn !== 1'b1) begin errors++; $display("FAIL legal_turn got %b exp 1", bus.turn); end
  endtask

  task automatic test_occupied();
    int da, ea, dc, ec, ra; logic ov;
    run_move(4'd4, da, ea, dc, ec, ra, ov);
    checks++; if (ea !== 2) begin errors++; $display("FAIL occ_err_at got %0d exp 2", ea); end
    checks++; if (ec !== 1) begin errors++; $display("FAIL occ_err_cnt got %0d exp 1", ec); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL occ_done_cnt got %0d exp 0", dc); end
    checks++; if (bus.board !== 18'h00100) begin errors++; $display("FAIL occ_board got %h exp 00100", bus.board); end
    checks++; if (bus.turn !== 1'b1) begin errors++; $display("FAIL occ_turn got %b exp 1", bus.turn); end
  endtask

  task automatic test_out_of_range();
    int da, ea, dc, ec, ra; logic ov;
    logic [IDX_W-1:0] bad [2] = '{4'd9, 4'd15};
    do_clear();
    for (int n = 0; n < 2; n++) begin
      run_move(bad[n], da, ea, dc, ec, ra, ov);
      checks++; if (ea !== 2 || ec !== 1 || dc !== 0) begin
        errors++; $display("FAIL range_err idx %0d got err_at %0d errs %0d dones %0d exp 2 1 0", bad[n], ea, ec, dc);
      end
      checks++; if (bus.board !== 18'h0) begin errors++; $display("FAIL range_board idx %0d got %h exp 0", bad[n], bus.board); end
    end
    checks++; if (bus.turn !== 1'b0) begin errors++; $display("FAIL range_turn got %b exp 0", bus.turn); end
  endtask

  task automatic test_win();
    int da, ea, dc, ec, ra; logic ov;
    logic [IDX_W-1:0] seq [5] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd2};
    do_clear();
    for (int n = 0; n < 5; n++) begin
      run_move(seq[n], da, ea, dc, ec, ra, ov);
      checks++; if (dc !== 1 || ec !== 0) begin
        errors++; $display("FAIL win_move%0d got dones %0d errs %0d exp 1 0", n, dc, ec);
      end
      if (n == 3) begin
        checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL win_early_over got %b exp 0", bus.game_over); end
      end
    end
    checks++; if (bus.board !== 18'h00295) begin errors++; $display("FAIL win_board got %h exp 00295", bus.board); end
    checks++; if (bus.turn !== 1'b1) begin errors++; $display("FAIL win_turn got %b exp 1", bus.turn); end
`ifdef BOARD_WIN_DETECT_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL win_over_at_done got %b exp 1", ov); end
    checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL win_over got %b exp 1", bus.game_over); end
    checks++; if (bus.winner !== 2'b01) begin errors++; $display("FAIL win_winner got %b exp 01", bus.winner); end
    run_move(4'd8, da, ea, dc, ec, ra, ov);
    checks++; if (ea !== 2 || dc !== 0) begin errors++; $display("FAIL win_after got err_at %0d dones %0d exp 2 0", ea, dc); end
    checks++; if (bus.board !== 18'h00295) begin errors++; $display("FAIL win_after_board got %h exp 00295", bus.board); end
`else
    checks++; if (bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin
      errors++; $display("FAIL win_tied got over %b winner %b exp 0 00", bus.game_over, bus.winner);
    end
    run_move(4'd8, da, ea, dc, ec, ra, ov);
    checks++; if (da !== 3 || ec !== 0) begin errors++; $display("FAIL win_after got done_at %0d errs %0d exp 3 0", da, ec); end
    checks++; if (bus.board !== 18'h20295) begin errors++; $display("FAIL win_after_board got %h exp 20295", bus.board); end
`endif
  endtask

  task automatic test_clear_in_check();
    int pulses = 0;
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd7;
    @(posedge clk);
    @(negedge clk);
    bus.move_valid = 1'b0;
    checks++; if (bus.move_ready !== 1'b0) begin errors++; $display("FAIL clr_busy got %b exp 0", bus.move_ready); end
    do_clear();
    checks++; if (bus.board !== 18'h0) begin errors++; $display("FAIL clr_board got %h exp 0", bus.board); end
    checks++; if (bus.turn !== 1'b0) begin errors++; $display("FAIL clr_turn got %b exp 0", bus.turn); end
    checks++; if (bus.move_ready !== 1'b1) begin errors++; $display("FAIL clr_ready got %b exp 1", bus.move_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.move_done || bus.move_err) pulses++;
    end
    checks++; if (pulses !== 0 || bus.board !== 18'h0) begin
      errors++; $display("FAIL clr_quiet got pulses %0d board %h exp 0 0", pulses, bus.board);
    end
  endtask

  task automatic test_clear_with_valid();
    int pulses = 0;
    int da, ea, dc, ec, ra; logic ov;
    run_move(4'd2, da, ea, dc, ec, ra, ov);
    bus.clear = 1'b1; bus.move_valid = 1'b1; bus.move_idx = 4'd0;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0; bus.move_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.move_ready !== 1'b1) begin errors++; $display("FAIL clrv_ready cyc %0d got %b exp 1", k, bus.move_ready); end
      if (bus.move_done || bus.move_err) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0 || bus.board !== 18'h0 || bus.turn !== 1'b0) begin
      errors++; $display("FAIL clrv_state got pulses %0d board %h turn %b exp 0 0 0", pulses, bus.board, bus.turn);
    end
  endtask

  task automatic test_reset_in_write();
    int pulses = 0;
    int da, ea, dc, ec, ra; logic ov;
    run_move(4'd6, da, ea, dc, ec, ra, ov);
    checks++; if (bus.board !== 18'h01000 || bus.turn !== 1'b1) begin
      errors++; $display("FAIL rstw_pre got board %h turn %b exp 01000 1", bus.board, bus.turn);
    end
    bus.move_valid = 1'b1;
    bus.move_idx   = 4'd5;
    @(posedge clk);
    #1 bus.move_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.board !== 18'h0 || bus.turn !== 1'b0) begin
      errors++; $display("FAIL rstw_state got board %h turn %b exp 0 0", bus.board, bus.turn);
    end
    checks++; if (bus.move_ready !== 1'b1 || bus.move_done !== 1'b0 || bus.move_err !== 1'b0) begin
      errors++; $display("FAIL rstw_hs got ready %b done %b err %b exp 1 0 0", bus.move_ready, bus.move_done, bus.move_err);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.move_done || bus.move_err) pulses++;
    end
    checks++; if (pulses !== 0 || bus.board !== 18'h0) begin
      errors++; $display("FAIL rstw_quiet got pulses %0d board %h exp 0 0", pulses, bus.board);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.clear = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_idx = '0;
    test_reset();
    test_legal_move();
    test_occupied();
    test_out_of_range();
    test_win();
    test_clear_in_check();
    test_clear_with_valid();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_move_writer.md
Name: board_move_writer

Overview:
Write side of the game board. Accepts one move request (cell index) per valid/ready handshake and validates it against the current board. On a legal move it demultiplexes the current player's code into the addressed cell register, then flips the turn. The flat board vector it drives is read elsewhere through the n-bit select muxes that feed display and VGA logic.

Parameters:
CELLS, 9, number of board cells; legal indices are 0..CELLS-1
IDX_W, 4, width of the move index
CODE_W, 2, bits per cell code; 00 = empty, 01 = X, 10 = O, 11 = reserved

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous new-game request; empties the board and sets turn to X
move_valid  in  1  a move request is presented
move_idx  in  IDX_W  cell index of the request
move_ready  out  1  block can accept a request (high only in IDLE)
move_done  out  1  one-cycle pulse: the move was written
move_err  out  1  one-cycle pulse: the move was rejected
turn  out  1  player to move; 0 = X, 1 = O
board  out  CELLS*CODE_W  flat board; cell i occupies bits [CODE_W*i+CODE_W-1 : CODE_W*i]
game_over  out  1  a win or draw is latched (meaningful only with the optional feature)
winner  out  CODE_W  winning code, or 00 if none or draw

Behaviour:
- Reset values: board all 00, turn = 0, state IDLE, move_ready = 1, move_done = 0, move_err = 0, game_over = 0, winner = 00.
- All outputs are registered. move_ready is decoded directly from the state register (IDLE).
- State machine has four states: IDLE, CHECK, WRITE, RESP.
  - IDLE: on edge E0 with move_valid & move_ready, capture move_idx into idx_q and go to CHECK. With no request, stay in IDLE.
  - CHECK: go to RESP with err_q = 1 if any of these hold: idx_q >= CELLS, cell[idx_q] != 00, or game_over = 1. Otherwise go to WRITE.
  - WRITE: cell[idx_q] <= (turn ? 10 : 01); turn <= ~turn; go to RESP with err_q = 0.
  - RESP: move_done = ~err_q and move_err = err_q, for exactly one cycle; then go to IDLE.
- Latency from the accepting edge E0:
  - Legal move: board and turn update at E0+3; move_done is high in the cycle after E0+3; move_ready returns after E0+4.
  - Rejected move: move_err is high in the cycle after E0+2; board and turn are unchanged.
- move_idx is sampled only at the handshake. Later changes to it, or to move_valid, while busy are ignored; no request queuing.
- Only the addressed cell is written. All other cells hold their value.
- Index values from CELLS to 2^IDX_W-1 (9..15 at defaults) are rejected. No wrap-around or modulo.
- clear is honoured in any state. Next cycle: board = 0, turn = 0, game_over = 0, winner = 00, state IDLE. A pending move is discarded with no done/err pulse.
- clear and move_valid in the same cycle: clear wins and the request is not accepted.
- reset has priority over clear. Reset mid-move aborts with no response pulse.

Optional Feature:
BOARD_WIN_DETECT_EN
- Defined:
  - In the cycle after each WRITE, the block evaluates the 8 lines (3 rows, 3 columns, 2 diagonals; valid for CELLS = 9).
  - If any line holds three equal non-empty codes, it latches game_over = 1 and winner = that code.
  - Otherwise, if all cells are non-empty, it latches game_over = 1 and winner = 00 (draw).
  - The result is valid in the same cycle as move_done.
  - Later moves are rejected via the game_over term in CHECK.
- Undefined: game_over and winner are tied to 0, and CHECK ignores the game_over term.

Test Plan:
- Reset, then move idx 4 -> move_done pulse at E0+4; board[9:8] = 01; turn = 1; move_ready back high the cycle after.
- Move idx 4 again after that -> move_err pulse at E0+3; board and turn unchanged.
- Move idx 9, then idx 15 -> move_err for each; board stays 0.
- X plays 0, 1, 2 with O on 3, 4 (feature on) -> after the fifth move, game_over = 1 and winner = 01; a following move to idx 8 gives move_err.
- Assert clear in the CHECK cycle of a legal move -> no done/err pulse; board = 0, turn = 0, move_ready = 1 next cycle.
- Assert clear and move_valid together, and separately reset during WRITE -> move not accepted; all outputs at reset values.
